// File: rtl/acc_ctrl_pkg.sv
// Shared types for the accelerator job controller: FSM state encoding and response status codes.
// No logic, no latency.
// No flow control of its own.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ACC_ST_OK      = 2'b00;
  localparam logic [1:0] ACC_ST_TIMEOUT = 2'b01;

endpackage

// File: rtl/acc_cycle_counter.sv
// Saturating cycle counter with clear/enable and terminal-count compare against TC.
// cnt updates one cycle after en; cnt_next and tc are combinational lookahead.
// No backpressure; the owner gates en.
module acc_cycle_counter #(
  parameter int W  = 16,
  parameter int TC = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_next,
  output logic         tc
);

  localparam logic [W-1:0] MAX  = '1;
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt;

  // cnt_next doubles as the reported latency, so it saturates too
  always_comb begin
    cnt_next = (cnt == MAX) ? MAX : cnt + ONE;
    tc       = (cnt_next == TC_V);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/accelerator_job_controller.sv
// One-at-a-time job sequencer: accept cmd, pulse acc_start, wait acc_finish (timeout when ACC_CTRL_TIMEOUT_EN), respond.
// Latency: acc_start one cycle after accept; response one cycle after the finish/timeout cycle.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module accelerator_job_controller
  import acc_ctrl_pkg::*;
#(
  parameter int ID_W           = 8,
  parameter int CYC_W          = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ID_W-1:0]  cmd_id,
  output logic             acc_start,
  input  logic             acc_finish,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [1:0]       rsp_status,
  output logic [CYC_W-1:0] rsp_cycles,
  output logic             busy
);

`ifdef ACC_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t             state, state_nxt;
  logic [ID_W-1:0]    job_id;
  logic               accept, cnt_clr, cnt_en, cnt_tc, timeout_hit, wait_done;
  logic [CYC_W-1:0]   cnt_next;

  acc_cycle_counter #(
    .W  (CYC_W),
    .TC (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt_next (cnt_next),
    .tc       (cnt_tc)
  );

  // held low while reset is asserted even though the state is already IDLE
  assign cmd_ready   = (state == ST_IDLE) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = TO_EN && cnt_tc;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    wait_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_START;
          cnt_clr   = 1'b1;
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (acc_finish || timeout_hit) begin
          wait_done = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      job_id     <= '0;
      acc_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_status <= ACC_ST_OK;
      rsp_cycles <= '0;
      busy       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_start <= (state_nxt == ST_START);
      rsp_valid <= (state_nxt == ST_RESP);
      busy      <= (state_nxt != ST_IDLE);
      if (accept) job_id <= cmd_id;
      // finish beats a coincident timeout
      if (wait_done) begin
        rsp_id     <= job_id;
        rsp_status <= acc_finish ? ACC_ST_OK : ACC_ST_TIMEOUT;
        rsp_cycles <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_accelerator_job_controller.sv
// Scoreboard bench for accelerator_job_controller; timeout scenarios run when ACC_CTRL_TIMEOUT_EN is defined.
module tb_accelerator_job_controller;
  import acc_ctrl_pkg::*;

`ifdef ACC_CTRL_TIMEOUT_EN
  localparam int TO     = 8;
  localparam bit TO_EN  = 1'b1;
  localparam int RST_AT = 5;
`else
  localparam int TO     = 1023;
  localparam bit TO_EN  = 1'b0;
  localparam int RST_AT = 38;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_id = '0;
  logic        acc_start;
  logic        acc_finish = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_id;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_cycles;
  logic        busy;

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  st;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  accelerator_job_controller #(
    .ID_W           (8),
    .CYC_W          (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .acc_start  (acc_start),
    .acc_finish (acc_finish),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_status (rsp_status),
    .rsp_cycles (rsp_cycles),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // d = WAIT cycle on which finish is pulsed (0 = never)
  function automatic exp_t model(input logic [7:0] id, input int d);
    exp_t e;
    e.id = id;
    if (TO_EN && (d == 0 || d > TO)) begin
      e.st  = ACC_ST_TIMEOUT;
      e.cyc = 16'(TO);
    end else begin
      e.st  = ACC_ST_OK;
      e.cyc = 16'(d);
    end
    return e;
  endfunction

  task automatic cmp_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_id"},  32'(rsp_id),     32'(e.id));
      check({tag, "_st"},  32'(rsp_status), 32'(e.st));
      check({tag, "_cyc"}, 32'(rsp_cycles), 32'(e.cyc));
    end
  endtask

  task automatic start_cmd(input logic [7:0] id, input bit push, input int d);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_id    = id;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("acc_start_rise", 32'(acc_start), 1);
    check("busy_start",     32'(busy),      1);
    check("cmd_ready_busy", 32'(cmd_ready), 0);
    if (push) sb.push_back(model(id, d));
  endtask

  // drives finish on WAIT cycle d, compares the response, then checks return to IDLE
  task automatic finish_job(input string tag, input int d);
    bit got = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      acc_finish = (i == d);
      if (i == 1) check({tag, "_start_pulse"}, 32'(acc_start), 0);
      if (rsp_valid && !got) begin
        cmp_rsp(tag);
        got = 1'b1;
      end
      if (got && i >= d) break;
    end
    if (!got) check({tag, "_rsp_budget"}, 0, 1);
    @(negedge clk);
    acc_finish = 1'b0;
    check({tag, "_rsp_drop"}, 32'(rsp_valid), 0);
    check({tag, "_idle"},     32'(busy),      0);
  endtask

  initial begin
    exp_t e;
    int   t;
    // reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_acc_start", 32'(acc_start), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id",    32'(rsp_id),    0);
    check("rst_rsp_st",    32'(rsp_status), 0);
    check("rst_rsp_cyc",   32'(rsp_cycles), 0);
    check("rst_busy",      32'(busy),      0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // stray finish while idle
    acc_finish = 1'b1;
    @(negedge clk);
    acc_finish = 1'b0;
    @(negedge clk);
    check("stray_idle_busy", 32'(busy),      0);
    check("stray_idle_rsp",  32'(rsp_valid), 0);
    check("stray_idle_rdy",  32'(cmd_ready), 1);

    start_cmd(8'h5A, 1'b1, 100);
    finish_job("job100", 100);
    start_cmd(8'h11, 1'b1, 1);
    finish_job("job_min", 1);
`ifdef ACC_CTRL_TIMEOUT_EN
    start_cmd(8'h22, 1'b1, 0);
    finish_job("timeout", 0);
    start_cmd(8'h33, 1'b1, TO + 2);
    finish_job("late_fin", TO + 2);
    start_cmd(8'h44, 1'b1, TO);
    finish_job("tie", TO);
`else
    start_cmd(8'h66, 1'b1, 2000);
    finish_job("long", 2000);
`endif

    // response backpressure with a pending command and stray finishes
    rsp_ready = 1'b0;
    start_cmd(8'h77, 1'b1, 5);
    t = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      acc_finish = (i == 5);
      t = i;
      if (rsp_valid) break;
    end
    acc_finish = 1'b0;
    check("bp_rsp_seen", 32'(rsp_valid), 1);
    e = model(8'h77, 5);
    cmp_rsp("bp");
    cmd_id    = 8'h88;
    cmd_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      acc_finish = (k % 3 == 0);
      @(negedge clk);
      check("bp_hold_vld", 32'(rsp_valid),  1);
      check("bp_hold_id",  32'(rsp_id),     32'(e.id));
      check("bp_hold_st",  32'(rsp_status), 32'(e.st));
      check("bp_hold_cyc", 32'(rsp_cycles), 32'(e.cyc));
      check("bp_hold_rdy", 32'(cmd_ready),  0);
      check("bp_hold_start", 32'(acc_start), 0);
    end
    acc_finish = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check("bp_rsp_done",   32'(rsp_valid), 0);
    check("bp_next_ready", 32'(cmd_ready), 1);
    sb.push_back(model(8'h88, 3));
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_start", 32'(acc_start), 1);
    finish_job("bp_second", 3);

    // reset in the middle of WAIT
    start_cmd(8'h99, 1'b0, 0);
    for (int i = 1; i <= RST_AT; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  32'(busy),       0);
    check("mid_rst_vld",   32'(rsp_valid),  0);
    check("mid_rst_start", 32'(acc_start),  0);
    check("mid_rst_id",    32'(rsp_id),     0);
    check("mid_rst_cyc",   32'(rsp_cycles), 0);
    check("mid_rst_rdy",   32'(cmd_ready),  0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid), 0);
    end
    start_cmd(8'hAB, 1'b1, 7);
    finish_job("after_rst", 7);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
